// File: rtl/enkel_pkg.sv
// Shared definitions for the external memory responder: bus widths, store depth and the
// loader state encoding.
package enkel_pkg;

    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEPTH      = 2 ** DEF_ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mem_array.sv
// Program/data store: one synchronous write port and a registered read port.
// Contents are deliberately left without reset so a reset never erases loaded bytes.
module mem_array
    import enkel_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned MEM_D  = DEPTH
) (
    input  logic              clk,
    input  logic              master_reset,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [MEM_D];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge master_reset) begin
        if (!master_reset) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory-side bus responder: answers CS/WE/OE strobes on the shared Data bus and lets a
// valid/ready byte-stream loader fill the store before the CPU runs.
module mem_responder
    import enkel_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              master_reset,
    input  logic              CS,
    input  logic              WE,
    input  logic              OE,
    input  logic [ADDR_W-1:0] Address,
    inout  wire  [DATA_W-1:0] Data,
    input  logic              prog_start,
    input  logic              prog_valid,
    input  logic [DATA_W-1:0] prog_byte,
    input  logic              prog_last,
    output logic              prog_ready,
    output logic              prog_done,
    output logic              busy
);

    localparam int unsigned MEM_DEPTH = 2 ** ADDR_W;

    state_e            r_state;
    state_e            w_state_next;
    logic [ADDR_W-1:0] r_count;
    logic [ADDR_W-1:0] w_count_next;
    logic              r_drive;

    logic              w_idle;
    logic              w_bus_ok;
    logic              w_bus_wr;
    logic              w_bus_rd;
    logic              w_hs;
    logic              w_load_end;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rdata;

    assign w_idle   = (r_state == IDLE);
    // A prog_start in the same cycle swallows any bus access.
    assign w_bus_ok = w_idle && !prog_start && CS;
    assign w_bus_wr = w_bus_ok && WE;
    assign w_bus_rd = w_bus_ok && OE && !WE;

    assign prog_ready = (r_state == LOAD);
    assign prog_done  = (r_state == DONE);
    assign busy       = !w_idle;

    assign w_hs       = prog_ready && prog_valid;
    assign w_load_end = w_hs && (prog_last || (r_count == {ADDR_W{1'b1}}));

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        case (r_state)
            IDLE: begin
                if (prog_start) begin
                    w_state_next = LOAD;
                    w_count_next = '0;
                end
            end
            LOAD: begin
                if (w_load_end) begin
                    w_state_next = DONE;
                    w_count_next = '0;
                end else if (w_hs) begin
                    w_count_next = r_count + 1'b1;
                end
            end
            DONE: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge master_reset) begin
        if (!master_reset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_drive <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_drive <= w_bus_rd;
        end
    end

    // Loader owns the write port whenever it is not idle.
    assign w_mem_we = w_bus_wr || w_hs;
    assign w_waddr  = w_idle ? Address : r_count;
    assign w_wdata  = w_idle ? Data : prog_byte;

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .MEM_D  (MEM_DEPTH)
    ) u_mem (
        .clk          (clk),
        .master_reset (master_reset),
        .i_we         (w_mem_we),
        .i_waddr      (w_waddr),
        .i_wdata      (w_wdata),
        .i_re         (w_bus_rd),
        .i_raddr      (Address),
        .o_rdata      (w_rdata)
    );

    assign Data = r_drive ? w_rdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_responder.sv
// Directed + randomized bench for mem_responder against a byte-array model of the store.
module tb_mem_responder;

    logic       clk = 1'b0;
    logic       master_reset = 1'b0;
    logic       CS = 1'b0, WE = 1'b0, OE = 1'b0;
    logic [7:0] Address = '0;
    wire  [7:0] Data;
    logic       prog_start = 1'b0, prog_valid = 1'b0, prog_last = 1'b0;
    logic [7:0] prog_byte = '0;
    logic       prog_ready, prog_done, busy;

    logic       tb_oe = 1'b0;
    logic [7:0] tb_dout = '0;
    assign Data = tb_oe ? tb_dout : 8'hzz;

    logic [7:0] mem_model [256];
    int         n_total = 0;
    int         n_pass  = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    mem_responder dut (
        .clk          (clk),
        .master_reset (master_reset),
        .CS           (CS),
        .WE           (WE),
        .OE           (OE),
        .Address      (Address),
        .Data         (Data),
        .prog_start   (prog_start),
        .prog_valid   (prog_valid),
        .prog_byte    (prog_byte),
        .prog_last    (prog_last),
        .prog_ready   (prog_ready),
        .prog_done    (prog_done),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        CS = 1'b0; WE = 1'b0; OE = 1'b0; tb_oe = 1'b0;
    endtask

    // Bench drives 0x00 alongside the DUT; any DUT drive shows up as a nonzero or X value.
    task automatic probe_hiz(input string tag);
        tb_oe = 1'b1; tb_dout = 8'h00;
        #1;
        check(tag, 32'(Data), 32'h0);
        tb_oe = 1'b0;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        CS = 1'b1; WE = 1'b1; OE = 1'b0; Address = a; tb_oe = 1'b1; tb_dout = d;
        @(negedge clk);
        bus_idle();
        mem_model[a] = d;
    endtask

    task automatic bus_read_check(input logic [7:0] a, input string tag);
        @(negedge clk);
        CS = 1'b1; WE = 1'b0; OE = 1'b1; Address = a; tb_oe = 1'b0;
        @(negedge clk);
        check(tag, 32'(Data), 32'(mem_model[a]));
        bus_idle();
    endtask

    task automatic start_load(input string tag);
        @(negedge clk);
        prog_start = 1'b1;
        @(negedge clk);
        prog_start = 1'b0;
        check({tag, " ready"}, 32'(prog_ready), 32'h1);
        check({tag, " busy"}, 32'(busy), 32'h1);
    endtask

    // Streams bytes starting at address 0; checks the single prog_done pulse at the end.
    task automatic load_bytes(input logic [7:0] q[$], input bit mark_last, input bit gaps,
                              input string tag);
        int done_seen = 0;
        for (int i = 0; i < q.size(); i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    if (prog_done) done_seen++;
                    prog_valid = 1'b0;
                    prog_byte  = $urandom();
                end
            end
            @(negedge clk);
            if (prog_done) done_seen++;
            prog_valid = 1'b1;
            prog_byte  = q[i];
            prog_last  = mark_last && (i == q.size() - 1);
        end
        @(negedge clk);
        prog_valid = 1'b0;
        prog_last  = 1'b0;
        check({tag, " done"}, 32'(prog_done), 32'h1);
        check({tag, " early done"}, 32'(done_seen), 32'h0);
        @(negedge clk);
        check({tag, " done width"}, 32'(prog_done), 32'h0);
        check({tag, " busy drop"}, 32'(busy), 32'h0);
        for (int i = 0; i < q.size(); i++) mem_model[i] = q[i];
    endtask

    initial begin
        logic [7:0] q[$];
        int         cnt;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst ready", 32'(prog_ready), 32'h0);
        check("rst done", 32'(prog_done), 32'h0);
        check("rst busy", 32'(busy), 32'h0);
        probe_hiz("rst hiz");
        master_reset = 1'b1;

        // Basic write then read, Data released before and after
        bus_write(8'h10, 8'h3C);
        @(negedge clk);
        probe_hiz("pre-read hiz");
        bus_read_check(8'h10, "read 0x10");
        @(negedge clk);
        probe_hiz("post-read hiz");

        // Short load with gaps and prog_last
        q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        start_load("short");
        load_bytes(q, 1'b1, 1'b1, "short");
        for (int a = 0; a < 5; a++) bus_read_check(8'(a), "short readback");

        // Full load, no prog_last: ends after byte 256
        q.delete();
        for (int a = 0; a < 256; a++) q.push_back(8'(a) ^ 8'hA5);
        start_load("full");
        load_bytes(q, 1'b0, 1'b0, "full");
        bus_read_check(8'h00, "full 0x00");
        bus_read_check(8'hFF, "full 0xFF");
        check("full model 0xFF", 32'(mem_model[255]), 32'h5A);

        // Bus strobes ignored while loading
        start_load("lock");
        @(negedge clk);
        CS = 1'b1; WE = 1'b1; Address = 8'h80; tb_oe = 1'b1; tb_dout = 8'h77;
        @(negedge clk);
        WE = 1'b0; OE = 1'b1; tb_oe = 1'b0;
        @(negedge clk);
        bus_idle();
        probe_hiz("load no drive");
        q = {8'h11};
        load_bytes(q, 1'b1, 1'b0, "lock");
        bus_read_check(8'h80, "load no write");
        bus_read_check(8'h00, "lock byte");

        // WE+OE: write wins, no drive; CS low: nothing happens
        @(negedge clk);
        CS = 1'b1; WE = 1'b1; OE = 1'b1; Address = 8'h20; tb_oe = 1'b1; tb_dout = 8'h42;
        @(negedge clk);
        bus_idle();
        mem_model[8'h20] = 8'h42;
        probe_hiz("we+oe no drive");
        @(negedge clk);
        CS = 1'b0; WE = 1'b1; OE = 1'b1; Address = 8'h20; tb_oe = 1'b1; tb_dout = 8'h99;
        @(negedge clk);
        bus_idle();
        bus_read_check(8'h20, "cs low no write");
        @(negedge clk);
        CS = 1'b0; WE = 1'b0; OE = 1'b1; Address = 8'h20;
        @(negedge clk);
        bus_idle();
        probe_hiz("cs low no drive");

        // prog_start beats a simultaneous bus write
        @(negedge clk);
        prog_start = 1'b1;
        CS = 1'b1; WE = 1'b1; Address = 8'h30; tb_oe = 1'b1; tb_dout = 8'hEE;
        @(negedge clk);
        prog_start = 1'b0;
        bus_idle();
        q = {8'h5B};
        load_bytes(q, 1'b1, 1'b0, "prio");
        bus_read_check(8'h30, "prio dropped");
        bus_read_check(8'h00, "prio byte");

        // Read the very next edge after a write
        @(negedge clk);
        CS = 1'b1; WE = 1'b1; Address = 8'h55; tb_oe = 1'b1; tb_dout = 8'hC7;
        @(negedge clk);
        WE = 1'b0; OE = 1'b1; tb_oe = 1'b0;
        mem_model[8'h55] = 8'hC7;
        @(negedge clk);
        check("wr then rd", 32'(Data), 32'hC7);
        bus_idle();

        // Back-to-back reads
        @(negedge clk);
        CS = 1'b1; OE = 1'b1; WE = 1'b0; Address = 8'h40;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            check("b2b read", 32'(Data), 32'(mem_model[8'(8'h40 + i - 1)]));
            Address = 8'(8'h40 + i);
        end
        @(negedge clk);
        check("b2b read", 32'(Data), 32'(mem_model[8'h43]));
        bus_idle();

        // Randomized bus traffic against the model
        for (int n = 0; n < 120; n++) begin
            logic [7:0] a;
            a = 8'($urandom());
            if ($urandom_range(0, 1) == 1) bus_write(a, 8'($urandom()));
            else bus_read_check(a, "rand read");
        end

        // Reset in the middle of a load
        @(negedge clk);
        start_load("abort");
        q = {8'hD1, 8'hD2, 8'hD3};
        for (int i = 0; i < 3; i++) begin
            prog_valid = 1'b1; prog_byte = q[i];
            @(negedge clk);
            mem_model[i] = q[i];
        end
        prog_valid = 1'b0;
        #2 master_reset = 1'b0;
        #1;
        check("abort ready", 32'(prog_ready), 32'h0);
        check("abort busy", 32'(busy), 32'h0);
        check("abort done", 32'(prog_done), 32'h0);
        @(negedge clk);
        master_reset = 1'b1;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (prog_done || busy) cnt++;
        end
        check("abort stays idle", 32'(cnt), 32'h0);
        for (int a = 0; a < 3; a++) bus_read_check(8'(a), "abort retained");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
